// File: rtl/sha512_mmio_master.sv
// sha512_mmio_master
// Host-side MMIO master for the SHA-512 AFU CSR block. Takes one host command
// at a time, issues it as a CCI-P style MMIO request, and for reads waits for
// the completion whose tid matches the outstanding request (or times out).
//
// The CCI-P MMIO request/completion structs are carried as flat fields:
//   mmio_rx_* : request toward the AFU (c0 Rx: mmioWrValid, mmioRdValid,
//               hdr.address, hdr.length, hdr.tid, data)
//   mmio_tx_* : read completion from the AFU (c2 Tx: mmioRdValid, hdr.tid, data)
//
// Ports
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_data : host command (held until accepted)
//   rsp_valid/rsp_data/rsp_timeout                  : one-cycle read response
//   stale_cnt                                       : saturating count of unmatched completions
module sha512_mmio_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [63:0] cmd_data,
    output logic        mmio_rx_wr_valid,
    output logic        mmio_rx_rd_valid,
    output logic [15:0] mmio_rx_hdr_address,
    output logic [1:0]  mmio_rx_hdr_length,
    output logic [8:0]  mmio_rx_hdr_tid,
    output logic [63:0] mmio_rx_data,
    input  logic        mmio_tx_rd_valid,
    input  logic [8:0]  mmio_tx_hdr_tid,
    input  logic [63:0] mmio_tx_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_timeout,
    output logic [7:0]  stale_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t            state, state_nxt;
    logic              cap_write;
    logic [15:0]       cap_addr;
    logic [63:0]       cap_data;
    logic [8:0]        tid;
    logic [8:0]        out_tid;
    logic [CNT_W-1:0]  wait_cnt;
    logic              accept;
    logic              match;
    logic              timed_out;

    assign accept    = cmd_valid && cmd_ready;
    // Only a completion for the single outstanding read counts; anything else is stale.
    assign match     = (state == WAIT_RD) && mmio_tx_rd_valid && (mmio_tx_hdr_tid == out_tid);
    // Asserted during the last allowed WAIT_RD cycle, so RESP begins exactly
    // TIMEOUT_CYCLES cycles after WAIT_RD was entered.
    assign timed_out = (state == WAIT_RD) && (wait_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        cmd_ready           = 1'b0;
        mmio_rx_wr_valid    = 1'b0;
        mmio_rx_rd_valid    = 1'b0;
        mmio_rx_hdr_address = '0;
        mmio_rx_hdr_length  = '0;
        mmio_rx_hdr_tid     = '0;
        mmio_rx_data        = '0;
        rsp_valid           = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                mmio_rx_wr_valid    = cap_write;
                mmio_rx_rd_valid    = !cap_write;
                mmio_rx_hdr_address = cap_addr;
                mmio_rx_hdr_length  = 2'b01;
                mmio_rx_hdr_tid     = tid;
                mmio_rx_data        = cap_data;
                state_nxt           = cap_write ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (match || timed_out) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_write   <= 1'b0;
            cap_addr    <= '0;
            cap_data    <= '0;
            tid         <= '0;
            out_tid     <= '0;
            wait_cnt    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            stale_cnt   <= '0;
        end else begin
            // command capture
            if (accept) begin
                cap_write <= cmd_write;
                cap_addr  <= cmd_addr;
                cap_data  <= cmd_data;
            end
            // read issue: remember the tid in flight, advance the counter (wraps 511->0)
            if (state == ISSUE && !cap_write) begin
                out_tid  <= tid;
                tid      <= tid + 9'd1;
                wait_cnt <= '0;
            end
            // completion wait; a match wins over a simultaneous timeout
            if (state == WAIT_RD) begin
                if (match) begin
                    rsp_data    <= mmio_tx_data;
                    rsp_timeout <= 1'b0;
                end else if (timed_out) begin
                    rsp_data    <= '0;
                    rsp_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
            if (mmio_tx_rd_valid && !match && stale_cnt != 8'hFF) begin
                stale_cnt <= stale_cnt + 8'd1;
            end
        end
    end

endmodule
